// File: rtl/slot_desc_manager.sv
// Packet-slot pool between the RX and TX DMA engines: free-slot FIFO, slot address table,
// RX/TX descriptor issue and per-slot lifecycle tracking (FREE -> RX -> TXQ -> TX -> FREE).
module slot_desc_manager #(
  parameter int SLOT_COUNT    = 16,
  parameter int SLOT_NO_WIDTH = 4,
  parameter int ADDR_WIDTH    = 7,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [SLOT_NO_WIDTH-1:0] slot_addr_wr_no,
  input  logic [ADDR_WIDTH-1:0]    slot_addr_wr_data,
  input  logic                     slot_addr_wr_valid,
  output logic [ADDR_WIDTH-1:0]    m_axis_rx_desc_addr,
  output logic [SLOT_NO_WIDTH-1:0] m_axis_rx_desc_tag,
  output logic                     m_axis_rx_desc_valid,
  input  logic                     m_axis_rx_desc_ready,
  input  logic [LEN_WIDTH-1:0]     s_axis_rx_desc_status_len,
  input  logic [SLOT_NO_WIDTH-1:0] s_axis_rx_desc_status_tag,
  input  logic                     s_axis_rx_desc_status_valid,
  output logic [ADDR_WIDTH-1:0]    m_axis_tx_desc_addr,
  output logic [LEN_WIDTH-1:0]     m_axis_tx_desc_len,
  output logic [SLOT_NO_WIDTH-1:0] m_axis_tx_desc_tag,
  output logic                     m_axis_tx_desc_valid,
  input  logic                     m_axis_tx_desc_ready,
  input  logic [SLOT_NO_WIDTH-1:0] s_axis_tx_desc_status_tag,
  input  logic                     s_axis_tx_desc_status_valid,
  output logic [SLOT_NO_WIDTH:0]   free_count,
  output logic                     init_done,
  output logic                     err_bad_rx_status,
  output logic                     err_bad_tx_status
);

  localparam int CW = SLOT_NO_WIDTH + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic [1:0] {SL_FREE, SL_RX, SL_TXQ, SL_TX} slot_st_t;

  state_t                   r_state, w_state_nxt;
  logic [SLOT_NO_WIDTH-1:0] r_init_cnt;
  logic                     w_init_push;

  logic [SLOT_NO_WIDTH-1:0] r_free_mem [SLOT_COUNT];
  logic [SLOT_NO_WIDTH-1:0] r_free_rd, r_free_wr;
  logic [CW-1:0]            r_free_cnt;

  logic [SLOT_NO_WIDTH-1:0] r_cmp_tag [SLOT_COUNT];
  logic [LEN_WIDTH-1:0]     r_cmp_len [SLOT_COUNT];
  logic [SLOT_NO_WIDTH-1:0] r_cmp_rd, r_cmp_wr;
  logic [CW-1:0]            r_cmp_cnt;

  logic [ADDR_WIDTH-1:0]    r_addr_tbl [SLOT_COUNT];
  slot_st_t                 r_slot_st [SLOT_COUNT];

  logic                     r_rx_valid, r_tx_valid;
  logic                     r_err_rx, r_err_tx;

  logic                     w_rx_cpl_ok, w_rx_cpl_bad, w_tx_cpl_ok, w_tx_cpl_bad;
  logic                     w_free_push, w_rx_load, w_tx_load;
  logic [SLOT_NO_WIDTH-1:0] w_free_push_tag, w_rx_slot, w_tx_slot;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_push = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_push = 1'b1;
        if (r_init_cnt == SLOT_NO_WIDTH'(SLOT_COUNT - 1)) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)              r_init_cnt <= '0;
    else if (w_init_push) r_init_cnt <= r_init_cnt + SLOT_NO_WIDTH'(1);
  end

  // Completions are judged against the slot state before this edge's updates.
  assign w_rx_cpl_ok  = s_axis_rx_desc_status_valid && (r_slot_st[s_axis_rx_desc_status_tag] == SL_RX);
  assign w_rx_cpl_bad = s_axis_rx_desc_status_valid && !w_rx_cpl_ok;
  assign w_tx_cpl_ok  = s_axis_tx_desc_status_valid && (r_slot_st[s_axis_tx_desc_status_tag] == SL_TX);
  assign w_tx_cpl_bad = s_axis_tx_desc_status_valid && !w_tx_cpl_ok;

  assign w_free_push     = w_init_push || w_tx_cpl_ok;
  assign w_free_push_tag = w_init_push ? r_init_cnt : s_axis_tx_desc_status_tag;

  assign w_rx_slot = r_free_mem[r_free_rd];
  assign w_rx_load = (!r_rx_valid || m_axis_rx_desc_ready) && (r_free_cnt != '0) &&
                     enable && (r_state == ST_RUN);
  assign w_tx_slot = r_cmp_tag[r_cmp_rd];
  assign w_tx_load = (!r_tx_valid || m_axis_tx_desc_ready) && (r_cmp_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_free_rd  <= '0;
      r_free_wr  <= '0;
      r_free_cnt <= '0;
    end else begin
      if (w_free_push) begin
        r_free_mem[r_free_wr] <= w_free_push_tag;
        r_free_wr             <= r_free_wr + SLOT_NO_WIDTH'(1);
      end
      if (w_rx_load) r_free_rd <= r_free_rd + SLOT_NO_WIDTH'(1);
      case ({w_free_push, w_rx_load})
        2'b10:   r_free_cnt <= r_free_cnt + CW'(1);
        2'b01:   r_free_cnt <= r_free_cnt - CW'(1);
        default: r_free_cnt <= r_free_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp_rd  <= '0;
      r_cmp_wr  <= '0;
      r_cmp_cnt <= '0;
    end else begin
      if (w_rx_cpl_ok) begin
        r_cmp_tag[r_cmp_wr] <= s_axis_rx_desc_status_tag;
        r_cmp_len[r_cmp_wr] <= s_axis_rx_desc_status_len;
        r_cmp_wr            <= r_cmp_wr + SLOT_NO_WIDTH'(1);
      end
      if (w_tx_load) r_cmp_rd <= r_cmp_rd + SLOT_NO_WIDTH'(1);
      case ({w_rx_cpl_ok, w_tx_load})
        2'b10:   r_cmp_cnt <= r_cmp_cnt + CW'(1);
        2'b01:   r_cmp_cnt <= r_cmp_cnt - CW'(1);
        default: r_cmp_cnt <= r_cmp_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOT_COUNT; i++)
        r_addr_tbl[i] <= ADDR_WIDTH'(i << (ADDR_WIDTH - SLOT_NO_WIDTH));
    end else if (slot_addr_wr_valid) begin
      r_addr_tbl[slot_addr_wr_no] <= slot_addr_wr_data;
    end
  end

  // A slot sits in exactly one stage, so these updates always hit distinct entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOT_COUNT; i++) r_slot_st[i] <= SL_FREE;
    end else begin
      if (w_init_push) r_slot_st[r_init_cnt]                <= SL_FREE;
      if (w_rx_load)   r_slot_st[w_rx_slot]                 <= SL_RX;
      if (w_rx_cpl_ok) r_slot_st[s_axis_rx_desc_status_tag] <= SL_TXQ;
      if (w_tx_load)   r_slot_st[w_tx_slot]                 <= SL_TX;
      if (w_tx_cpl_ok) r_slot_st[s_axis_tx_desc_status_tag] <= SL_FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_valid          <= 1'b0;
      m_axis_rx_desc_addr <= '0;
      m_axis_rx_desc_tag  <= '0;
    end else if (w_rx_load) begin
      r_rx_valid          <= 1'b1;
      m_axis_rx_desc_addr <= r_addr_tbl[w_rx_slot];
      m_axis_rx_desc_tag  <= w_rx_slot;
    end else if (m_axis_rx_desc_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_valid          <= 1'b0;
      m_axis_tx_desc_addr <= '0;
      m_axis_tx_desc_len  <= '0;
      m_axis_tx_desc_tag  <= '0;
    end else if (w_tx_load) begin
      r_tx_valid          <= 1'b1;
      m_axis_tx_desc_addr <= r_addr_tbl[w_tx_slot];
      m_axis_tx_desc_len  <= r_cmp_len[r_cmp_rd];
      m_axis_tx_desc_tag  <= w_tx_slot;
    end else if (m_axis_tx_desc_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_rx <= 1'b0;
      r_err_tx <= 1'b0;
    end else begin
      r_err_rx <= w_rx_cpl_bad;
      r_err_tx <= w_tx_cpl_bad;
    end
  end

  assign m_axis_rx_desc_valid = r_rx_valid;
  assign m_axis_tx_desc_valid = r_tx_valid;
  assign free_count           = r_free_cnt;
  assign init_done            = (r_state == ST_RUN);
  assign err_bad_rx_status    = r_err_rx;
  assign err_bad_tx_status    = r_err_tx;

endmodule

// File: tb/tb_slot_desc_manager.sv
// Bench for slot_desc_manager: slot-pool reference model with descriptor scoreboards,
// directed lifecycle/boundary scenarios and a randomized backpressure run with mid-traffic reset.
module tb_slot_desc_manager;
  localparam int SC = 16, SW = 4, AW = 7, LW = 16;
  localparam int M_FREE = 0, M_RX = 1, M_TXQ = 2, M_TX = 3;

  logic clk = 1'b0;
  logic rst, enable;
  logic [SW-1:0] slot_addr_wr_no;
  logic [AW-1:0] slot_addr_wr_data;
  logic slot_addr_wr_valid;
  logic [AW-1:0] rx_addr;
  logic [SW-1:0] rx_tag;
  logic rx_valid, rx_ready;
  logic [LW-1:0] s_rx_len;
  logic [SW-1:0] s_rx_tag;
  logic s_rx_valid;
  logic [AW-1:0] tx_addr;
  logic [LW-1:0] tx_len;
  logic [SW-1:0] tx_tag;
  logic tx_valid, tx_ready;
  logic [SW-1:0] s_tx_tag;
  logic s_tx_valid;
  logic [SW:0] free_count;
  logic init_done, err_bad_rx, err_bad_tx;

  always #5 clk = ~clk;

  slot_desc_manager #(.SLOT_COUNT(SC), .SLOT_NO_WIDTH(SW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .slot_addr_wr_no(slot_addr_wr_no), .slot_addr_wr_data(slot_addr_wr_data),
    .slot_addr_wr_valid(slot_addr_wr_valid),
    .m_axis_rx_desc_addr(rx_addr), .m_axis_rx_desc_tag(rx_tag),
    .m_axis_rx_desc_valid(rx_valid), .m_axis_rx_desc_ready(rx_ready),
    .s_axis_rx_desc_status_len(s_rx_len), .s_axis_rx_desc_status_tag(s_rx_tag),
    .s_axis_rx_desc_status_valid(s_rx_valid),
    .m_axis_tx_desc_addr(tx_addr), .m_axis_tx_desc_len(tx_len), .m_axis_tx_desc_tag(tx_tag),
    .m_axis_tx_desc_valid(tx_valid), .m_axis_tx_desc_ready(tx_ready),
    .s_axis_tx_desc_status_tag(s_tx_tag), .s_axis_tx_desc_status_valid(s_tx_valid),
    .free_count(free_count), .init_done(init_done),
    .err_bad_rx_status(err_bad_rx), .err_bad_tx_status(err_bad_tx)
  );

  typedef struct { int tag; int addr; int len; } exp_t;

  exp_t rx_exp[$];
  exp_t tx_exp[$];
  int   m_st[SC];
  int   m_addr[SC];
  int   hs_cyc[$];
  bit   drv_bad_rx, drv_bad_tx;
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout_chk(string name, bit ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    end
  endfunction

  // Monitor: pops expected descriptors on each handshake, checks stall stability and error pulses.
  bit            p_rx_stall, p_tx_stall, l_bad_rx, l_bad_tx;
  logic [AW-1:0] p_rx_addr, p_tx_addr;
  logic [SW-1:0] p_rx_tag, p_tx_tag;
  logic [LW-1:0] p_tx_len;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      p_rx_stall = 0; p_tx_stall = 0; l_bad_rx = 0; l_bad_tx = 0;
    end else begin
      chk("err_bad_rx_status", err_bad_rx, l_bad_rx);
      chk("err_bad_tx_status", err_bad_tx, l_bad_tx);
      l_bad_rx = drv_bad_rx;
      l_bad_tx = drv_bad_tx;
      if (p_rx_stall) begin
        chk("rx_hold_valid", rx_valid, 1);
        chk("rx_hold_addr", rx_addr, p_rx_addr);
        chk("rx_hold_tag", rx_tag, p_rx_tag);
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rx_unexpected: tag %0d issued, expected none", rx_tag);
        end else begin
          e = rx_exp.pop_front();
          chk("rx_tag", rx_tag, e.tag);
          chk("rx_addr", rx_addr, e.addr);
          m_st[e.tag] = M_RX;
          hs_cyc.push_back(cyc);
        end
      end
      p_rx_stall = rx_valid && !rx_ready;
      p_rx_addr = rx_addr; p_rx_tag = rx_tag;
      if (p_tx_stall) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_addr", tx_addr, p_tx_addr);
        chk("tx_hold_len", tx_len, p_tx_len);
        chk("tx_hold_tag", tx_tag, p_tx_tag);
      end
      if (tx_valid && tx_ready) begin
        if (tx_exp.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL tx_unexpected: tag %0d issued, expected none", tx_tag);
        end else begin
          e = tx_exp.pop_front();
          chk("tx_tag", tx_tag, e.tag);
          chk("tx_addr", tx_addr, e.addr);
          chk("tx_len", tx_len, e.len);
          m_st[e.tag] = M_TX;
        end
      end
      p_tx_stall = tx_valid && !tx_ready;
      p_tx_addr = tx_addr; p_tx_len = tx_len; p_tx_tag = tx_tag;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    s_rx_valid = 0; s_tx_valid = 0; slot_addr_wr_valid = 0;
    drv_bad_rx = 0; drv_bad_tx = 0;
  endtask

  // After reset the pool holds every slot in index order at its default address.
  task automatic m_reset();
    exp_t e;
    rx_exp.delete(); tx_exp.delete(); hs_cyc.delete();
    for (int i = 0; i < SC; i++) begin
      m_st[i] = M_FREE;
      m_addr[i] = i * (1 << (AW - SW));
      e.tag = i; e.addr = m_addr[i]; e.len = 0;
      rx_exp.push_back(e);
    end
  endtask

  task automatic rx_cpl(int tag, int len);
    exp_t e;
    s_rx_tag = SW'(tag); s_rx_len = LW'(len); s_rx_valid = 1;
    if (m_st[tag] == M_RX) begin
      m_st[tag] = M_TXQ;
      e.tag = tag; e.addr = m_addr[tag]; e.len = len;
      tx_exp.push_back(e);
    end else drv_bad_rx = 1;
  endtask

  task automatic tx_cpl(int tag);
    exp_t e;
    s_tx_tag = SW'(tag); s_tx_valid = 1;
    if (m_st[tag] == M_TX) begin
      m_st[tag] = M_FREE;
      e.tag = tag; e.addr = m_addr[tag]; e.len = 0;
      rx_exp.push_back(e);
    end else drv_bad_tx = 1;
  endtask

  task automatic addr_wr(int slot, int val);
    slot_addr_wr_no = SW'(slot); slot_addr_wr_data = AW'(val); slot_addr_wr_valid = 1;
    m_addr[slot] = val;
  endtask

  function automatic int pick(int s1, int s2);
    int c[$];
    for (int i = 0; i < SC; i++) if (m_st[i] == s1 || m_st[i] == s2) c.push_back(i);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  function automatic int count_free();
    int n = 0;
    for (int i = 0; i < SC; i++) if (m_st[i] == M_FREE) n++;
    return n;
  endfunction

  task automatic wait_st(int slot, int st, string name);
    for (int i = 0; i < 60 && m_st[slot] != st; i++) cycle();
    timeout_chk(name, m_st[slot] == st);
  endtask

  task automatic check_reset(string p);
    chk({p, "_rx_valid"}, rx_valid, 0);   chk({p, "_rx_addr"}, rx_addr, 0);
    chk({p, "_rx_tag"}, rx_tag, 0);       chk({p, "_tx_valid"}, tx_valid, 0);
    chk({p, "_tx_addr"}, tx_addr, 0);     chk({p, "_tx_len"}, tx_len, 0);
    chk({p, "_tx_tag"}, tx_tag, 0);       chk({p, "_free_count"}, free_count, 0);
    chk({p, "_init_done"}, init_done, 0); chk({p, "_err_rx"}, err_bad_rx, 0);
    chk({p, "_err_tx"}, err_bad_tx, 0);
  endtask

  task automatic check_init(string p);
    for (int k = 1; k <= SC; k++) begin
      cycle();
      chk({p, "_free_count"}, free_count, k);
      chk({p, "_init_done"}, init_done, (k == SC) ? 1 : 0);
      chk({p, "_no_rx_valid"}, rx_valid, 0);
    end
  endtask

  initial begin
    int rt, tt, w, v, stable;
    rst = 1; enable = 0; rx_ready = 0; tx_ready = 0;
    s_rx_valid = 0; s_rx_tag = '0; s_rx_len = '0; s_tx_valid = 0; s_tx_tag = '0;
    slot_addr_wr_valid = 0; slot_addr_wr_no = '0; slot_addr_wr_data = '0;
    drv_bad_rx = 0; drv_bad_tx = 0;
    m_reset();
    repeat (4) cycle();
    check_reset("reset");
    rst = 0;
    check_init("init");
    cycle();
    chk("idle_no_rx_valid", rx_valid, 0);
    chk("idle_free_count", free_count, SC);

    // Issue order: all 16 slots back to back at default addresses.
    enable = 1; rx_ready = 1; tx_ready = 1;
    for (int i = 0; i < 40 && !(rx_exp.size() == 0 && !rx_valid); i++) cycle();
    timeout_chk("issue_drain", rx_exp.size() == 0);
    chk("issue_free_count", free_count, 0);
    chk("issue_valid_drop", rx_valid, 0);
    chk("issue_count", hs_cyc.size(), SC);
    for (int i = 1; i < hs_cyc.size(); i++) chk("issue_back_to_back", hs_cyc[i] - hs_cyc[i-1], 1);

    // RX completion to TX descriptor, then recycle.
    rx_cpl(5, 64);
    cycle(); chk("tx_latency_1", tx_valid, 0);
    cycle(); chk("tx_latency_2", tx_valid, 1);
    chk("tx5_tag", tx_tag, 5); chk("tx5_len", tx_len, 64); chk("tx5_addr", tx_addr, 'h28);
    wait_st(5, M_TX, "tx5_handshake");
    tx_cpl(5);
    cycle(); chk("recycle_latency_1", rx_valid, 0);
    cycle(); chk("recycle_latency_2", rx_valid, 1);
    chk("recycle_tag", rx_tag, 5); chk("recycle_addr", rx_addr, 'h28);
    wait_st(5, M_RX, "recycle_handshake");
    enable = 0;

    // Address write while slot 2 is free.
    rx_cpl(2, 100); wait_st(2, M_TX, "slot2_tx");
    tx_cpl(2); cycle(); cycle();
    addr_wr(2, 'h7F);
    foreach (rx_exp[i]) if (rx_exp[i].tag == 2) rx_exp[i].addr = m_addr[2];
    cycle();
    enable = 1; wait_st(2, M_RX, "addr_free_handshake"); enable = 0;

    // Address write while slot 2's descriptor is stalled: old address kept.
    rx_ready = 0;
    rx_cpl(2, 200); wait_st(2, M_TX, "slot2_tx_again");
    tx_cpl(2); cycle();
    enable = 1; cycle(); enable = 0;
    addr_wr(2, 'h11); cycle();
    repeat (3) cycle();
    chk("stall_hold_valid", rx_valid, 1);
    chk("stall_keeps_addr", rx_addr, 'h7F);
    rx_ready = 1; wait_st(2, M_RX, "stall_release");

    // Illegal TX completion on a free slot.
    rx_cpl(9, 9); wait_st(9, M_TX, "slot9_tx");
    tx_cpl(9); cycle(); cycle();
    chk("free_before_bad_tx", free_count, count_free());
    tx_cpl(9);
    cycle(); chk("bad_tx_pulse", err_bad_tx, 1);
    cycle(); chk("bad_tx_pulse_end", err_bad_tx, 0);
    chk("free_after_bad_tx", free_count, count_free());

    // Repeated RX completion.
    rx_cpl(3, 33);
    cycle(); chk("good_rx_no_pulse", err_bad_rx, 0);
    rx_cpl(3, 34);
    cycle(); chk("bad_rx_pulse", err_bad_rx, 1);
    wait_st(3, M_TX, "slot3_tx");

    // Randomized traffic with backpressure and a mid-traffic reset.
    enable = 1;
    for (int it = 0; it < 10000; it++) begin
      cycle();
      if (it == 5000) begin
        rst = 1; rx_ready = 1; tx_ready = 1;
        m_reset();
        cycle(); check_reset("mid_reset");
        cycle(); cycle();
        rst = 0;
        check_init("reinit");
      end else begin
        rx_ready = ($urandom_range(0, 9) < 7);
        tx_ready = ($urandom_range(0, 9) < 7);
        rt = -1;
        v = $urandom_range(0, 99);
        if (v < 30) begin
          rt = pick(M_RX, M_RX);
          if (rt >= 0) rx_cpl(rt, $urandom_range(0, 65535));
        end else if (v < 36) begin
          rt = pick(M_TXQ, M_TX);
          if (rt >= 0) rx_cpl(rt, $urandom_range(0, 65535));
        end
        v = $urandom_range(0, 99);
        if (v < 30) begin
          tt = pick(M_TX, M_TX);
          if (tt >= 0) tx_cpl(tt);
        end else if (v < 36) begin
          tt = pick(M_FREE, M_RX);
          if (tt >= 0) tx_cpl(tt);
        end
        if ($urandom_range(0, 99) < 8) begin
          w = pick(M_RX, M_RX);
          if (w >= 0 && w != rt) addr_wr(w, $urandom_range(0, (1 << AW) - 1));
        end
      end
    end

    // Drain: every slot must come home exactly once.
    enable = 0; rx_ready = 1; tx_ready = 1;
    stable = 0;
    for (int i = 0; i < 3000 && stable < 5; i++) begin
      cycle();
      rt = pick(M_RX, M_RX);
      if (rt >= 0) rx_cpl(rt, $urandom_range(0, 65535));
      tt = pick(M_TX, M_TX);
      if (tt >= 0) tx_cpl(tt);
      if (count_free() == SC) stable++; else stable = 0;
    end
    timeout_chk("drain_complete", stable >= 5);
    chk("drain_free_count", free_count, SC);
    chk("drain_rx_exp", rx_exp.size(), SC);
    chk("drain_tx_exp", tx_exp.size(), 0);
    chk("drain_rx_valid", rx_valid, 0);
    chk("drain_tx_valid", tx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
